deser_queue: RTL and testbench



---
 rtl/deser_queue_pkg.sv | 21 ++
 rtl/deser_queue_if.sv | 30 +++
 rtl/word_fifo.sv | 65 ++++++
 rtl/deser_queue.sv | 174 +++++++++++++++++
 tb/tb_deser_queue.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/deser_queue_pkg.sv
// deser_queue_pkg: shared types and helpers for the deser_queue block.
//   deser_state_t : receive FSM states (IDLE, RECV, PUSH, WAIT_ROOM)
//   even_parity   : XOR reduction used for the optional parity check
package deser_queue_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RECV      = 2'd1,
        PUSH      = 2'd2,
        WAIT_ROOM = 2'd3
    } deser_state_t;

    // Widest data word the parity helper can cover.
    localparam int PARITY_MAX_W = 64;

    // Returns the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/deser_queue_if.sv
// deser_queue_if: serial input, pop request and queue status bundle.
//   master : producer/consumer side (drives data_in, write_in, dequeue_in)
//   slave  : deser_queue side (drives status, data, occupancy and error flags)
interface deser_queue_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) ();
    logic                         data_in;
    logic                         write_in;
    logic                         status_out;
    logic                         dequeue_in;
    logic [DATA_WIDTH-1:0]        data_out;
    logic [$clog2(DEPTH+1)-1:0]   len_out;
    logic                         full_out;
    logic                         empty_out;
    logic                         overflow_out;
    logic                         parity_err_out;

    modport master (
        output data_in, write_in, dequeue_in,
        input  status_out, data_out, len_out, full_out, empty_out,
               overflow_out, parity_err_out
    );

    modport slave (
        input  data_in, write_in, dequeue_in,
        output status_out, data_out, len_out, full_out, empty_out,
               overflow_out, parity_err_out
    );
endinterface

// File: rtl/word_fifo.sv
// word_fifo: DEPTH-entry circular word queue with registered read data.
//   clock, reset : system clock, asynchronous active-low reset
//   push, wdata  : write one word (caller guarantees room)
//   pop_req      : pop request; ignored while empty, data_out then holds
//   data_out     : last popped word
//   len_out      : occupancy; full_out / empty_out decoded from it
module word_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [DATA_WIDTH-1:0]      wdata,
    input  logic                       pop_req,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic [$clog2(DEPTH+1)-1:0] len_out,
    output logic                       full_out,
    output logic                       empty_out
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [LW-1:0]         len_q;
    logic                  do_push;
    logic                  do_pop;

    assign full_out  = (len_q == LW'(DEPTH));
    assign empty_out = (len_q == '0);
    assign len_out   = len_q;
    assign do_push   = push & ~full_out;
    assign do_pop    = pop_req & ~empty_out;

    // Storage carries no reset; only pointers and occupancy define validity.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            len_q    <= '0;
            data_out <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr   <= rd_ptr + AW'(1);
                data_out <= mem[rd_ptr];
            end
            unique case ({do_push, do_pop})
                2'b10:   len_q <= len_q + LW'(1);
                2'b01:   len_q <= len_q - LW'(1);
                default: len_q <= len_q;
            endcase
        end
    end
endmodule

// File: rtl/deser_queue.sv
// deser_queue: serial-to-parallel front end feeding a word queue.
//   clock, reset : system clock, asynchronous active-low reset
//   bus (slave)  : data_in/write_in serial input (bit taken on write_in 0->1),
//                  status_out ready, dequeue_in pop, data_out/len_out/
//                  full_out/empty_out queue view, overflow_out sticky flag,
//                  parity_err_out one-cycle pulse
// Optional feature: define DESER_PARITY_EN to append an even-parity bit to
// every word; failing words are dropped and flagged.
module deser_queue
    import deser_queue_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int MSB_FIRST  = 0
) (
    input  logic          clock,
    input  logic          reset,
    deser_queue_if.slave  bus
);
`ifdef DESER_PARITY_EN
    localparam int NBITS = DATA_WIDTH + 1;
`else
    localparam int NBITS = DATA_WIDTH;
`endif
    localparam int CW = $clog2(NBITS + 1);

    deser_state_t          state_q, state_d;
    logic                  write_q;
    logic                  strobe;
    logic [CW-1:0]         cnt_q;
    logic [DATA_WIDTH-1:0] word_q;
    logic                  last_bit;
    logic                  capture;
    logic                  push;
    logic                  set_ovf;
    logic                  overflow_q;
    logic                  full;
    logic                  status;

    assign strobe   = bus.write_in & ~write_q;
    assign last_bit = (cnt_q == CW'(NBITS - 1));

`ifdef DESER_PARITY_EN
    logic par_ok;
    logic par_fail;
    logic perr_q;
    // The strobe that completes the frame carries the parity bit itself.
    assign par_ok = (even_parity(PARITY_MAX_W'(word_q)) == bus.data_in);
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        push    = 1'b0;
        set_ovf = 1'b0;
        status  = 1'b0;
`ifdef DESER_PARITY_EN
        par_fail = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                status = 1'b1;
                if (strobe) begin
                    if (full) begin
                        set_ovf = 1'b1;
                        state_d = WAIT_ROOM;
                    end else begin
                        capture = 1'b1;
                        state_d = RECV;
                    end
                end
            end
            RECV: begin
                if (strobe) begin
                    capture = 1'b1;
                    if (last_bit) begin
`ifdef DESER_PARITY_EN
                        if (par_ok) begin
                            state_d = PUSH;
                        end else begin
                            par_fail = 1'b1;
                            state_d  = IDLE;
                        end
`else
                        state_d = PUSH;
`endif
                    end
                end
            end
            PUSH: begin
                // Strobes landing here are dropped; senders wait for status.
                push    = 1'b1;
                state_d = IDLE;
            end
            WAIT_ROOM: begin
                if (strobe) begin
                    set_ovf = 1'b1;
                end
                if (!full) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            write_q    <= 1'b0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            write_q <= bus.write_in;
            if (capture) begin
                cnt_q <= last_bit ? '0 : cnt_q + CW'(1);
            end
            if (set_ovf) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Bits land directly at their final word position, so no shift is needed
    // and a frame aborted by reset simply gets overwritten by the next one.
    always_ff @(posedge clock) begin
        if (capture) begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                if (cnt_q == CW'((MSB_FIRST != 0) ? (DATA_WIDTH - 1 - i) : i)) begin
                    word_q[i] <= bus.data_in;
                end
            end
        end
    end

`ifdef DESER_PARITY_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= par_fail;
        end
    end
    assign bus.parity_err_out = perr_q;
`else
    assign bus.parity_err_out = 1'b0;
`endif

    assign bus.status_out   = status;
    assign bus.overflow_out = overflow_q;
    assign bus.full_out     = full;

    word_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .wdata      (word_q),
        .pop_req    (bus.dequeue_in),
        .data_out   (bus.data_out),
        .len_out    (bus.len_out),
        .full_out   (full),
        .empty_out  (bus.empty_out)
    );
endmodule

// File: tb/tb_deser_queue.sv
// tb_deser_queue: drives an LSB-first and an MSB-first deser_queue from the
// same serial stream and compares both against a queue-based model every
// cycle, plus fixed expectations for the directed scenarios.
module tb_deser_queue;
    localparam int W  = 8;
    localparam int D  = 8;
`ifdef DESER_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    logic din   = 1'b0;
    logic win   = 1'b0;
    logic deq   = 1'b0;
    bit   rand_pop = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   perr_cnt = 0;

    always #500 clock = ~clock;

    deser_queue_if #(.DATA_WIDTH(W), .DEPTH(D)) bus_l ();
    deser_queue_if #(.DATA_WIDTH(W), .DEPTH(D)) bus_m ();

    assign bus_l.data_in    = din;
    assign bus_l.write_in   = win;
    assign bus_l.dequeue_in = deq;
    assign bus_m.data_in    = din;
    assign bus_m.write_in   = win;
    assign bus_m.dequeue_in = deq;

    deser_queue #(.DATA_WIDTH(W), .DEPTH(D), .MSB_FIRST(0)) dut_l (
        .clock (clock), .reset (rst_n), .bus (bus_l)
    );
    deser_queue #(.DATA_WIDTH(W), .DEPTH(D), .MSB_FIRST(1)) dut_m (
        .clock (clock), .reset (rst_n), .bus (bus_m)
    );

    // ---------------- behavioural model ----------------
    logic [W-1:0] mq_l[$];
    logic [W-1:0] mq_m[$];
    bit           m_bits[$];
    logic [W-1:0] m_data_l = '0;
    logic [W-1:0] m_data_m = '0;
    logic [W-1:0] pend_l = '0;
    logic [W-1:0] pend_m = '0;
    bit m_ovf = 0, m_perr = 0, m_pend = 0, m_blocked = 0, m_prevw = 0;

    task automatic model_reset();
        mq_l.delete(); mq_m.delete(); m_bits.delete();
        m_data_l = '0; m_data_m = '0;
        m_ovf = 0; m_perr = 0; m_pend = 0; m_blocked = 0; m_prevw = 0;
    endtask

    task automatic model_step();
        int  size0;
        bit  strobe;
        logic [W-1:0] wl, wm;
        size0   = mq_l.size();
        strobe  = win && !m_prevw;
        m_prevw = win;
        m_perr  = 0;
        if (deq && size0 > 0) begin
            m_data_l = mq_l.pop_front();
            m_data_m = mq_m.pop_front();
        end
        if (m_pend) begin
            mq_l.push_back(pend_l);
            mq_m.push_back(pend_m);
            m_pend = 0;
        end else if (m_blocked) begin
            if (strobe) m_ovf = 1;
            if (size0 < D) m_blocked = 0;
        end else if (strobe) begin
            if (m_bits.size() == 0 && size0 == D) begin
                m_ovf = 1;
                m_blocked = 1;
            end else begin
                m_bits.push_back(din);
                if (m_bits.size() == NB) begin
                    wl = '0; wm = '0;
                    for (int k = 0; k < W; k++) begin
                        wl[k]     = m_bits[k];
                        wm[W-1-k] = m_bits[k];
                    end
                    if (NB == W || m_bits[NB-1] == (^wl)) begin
                        pend_l = wl; pend_m = wm; m_pend = 1;
                    end else begin
                        m_perr = 1;
                    end
                    m_bits.delete();
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clock or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        logic exp_status;
        exp_status = (m_bits.size() == 0) && !m_pend && !m_blocked;
        chk("status_l", 32'(bus_l.status_out), 32'(exp_status));
        chk("status_m", 32'(bus_m.status_out), 32'(exp_status));
        chk("len_l",    32'(bus_l.len_out),    32'(mq_l.size()));
        chk("len_m",    32'(bus_m.len_out),    32'(mq_m.size()));
        chk("full_l",   32'(bus_l.full_out),   32'(mq_l.size() == D));
        chk("empty_l",  32'(bus_l.empty_out),  32'(mq_l.size() == 0));
        chk("ovf_l",    32'(bus_l.overflow_out), 32'(m_ovf));
        chk("ovf_m",    32'(bus_m.overflow_out), 32'(m_ovf));
        chk("perr_l",   32'(bus_l.parity_err_out), 32'(m_perr));
        chk("data_l",   32'(bus_l.data_out),   32'(m_data_l));
        chk("data_m",   32'(bus_m.data_out),   32'(m_data_m));
        if (bus_l.parity_err_out) perr_cnt++;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clock);
        if (rand_pop) deq = ($urandom_range(0, 3) == 0);
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic send_bit(input bit b, input int hi, input int lo);
        din = b; win = 1'b1;
        ticks(hi);
        win = 1'b0;
        ticks(lo);
    endtask

    task automatic send_word(input logic [W-1:0] w, input int hi, input int lo);
        for (int k = 0; k < W; k++) send_bit(w[k], hi, lo);
`ifdef DESER_PARITY_EN
        send_bit(^w, hi, lo);
`endif
    endtask

`ifdef DESER_PARITY_EN
    task automatic send_word_p(input logic [W-1:0] w, input bit pbit);
        for (int k = 0; k < W; k++) send_bit(w[k], 10, 10);
        send_bit(pbit, 10, 10);
    endtask
`endif

    task automatic wait_status(input string who);
        int n;
        n = 0;
        while (!bus_l.status_out && n < 200) begin
            tick();
            n++;
        end
        chk(who, 32'(bus_l.status_out), 32'd1);
    endtask

    task automatic pop();
        deq = 1'b1;
        tick();
        deq = 1'b0;
    endtask

    initial begin
        logic [W-1:0] w;
        int p0;
        ticks(3);
        chk("rst_len",    32'(bus_l.len_out), 32'd0);
        chk("rst_empty",  32'(bus_l.empty_out), 32'd1);
        chk("rst_full",   32'(bus_l.full_out), 32'd0);
        chk("rst_data",   32'(bus_l.data_out), 32'h0);
        chk("rst_ovf",    32'(bus_l.overflow_out), 32'd0);
        #250 rst_n = 1'b1;
        tick();
        chk("rst_status", 32'(bus_l.status_out), 32'd1);

        // Scenario 1: 0x99 LSB-first, then one pop
        wait_status("s1_ready");
        send_word(8'h99, 10, 10);
        chk("s1_len1", 32'(bus_l.len_out), 32'd1);
        pop();
        chk("s1_len0", 32'(bus_l.len_out), 32'd0);
        chk("s1_data", 32'(bus_l.data_out), 32'h99);

        // Scenario 2: serial 1,0,0,0,0,0,0,0
        wait_status("s2_ready");
        send_word(8'h01, 10, 10);
        pop();
        chk("s2_data_msb", 32'(bus_m.data_out), 32'h80);
        chk("s2_data_lsb", 32'(bus_l.data_out), 32'h01);

        // Scenario 3: fill, overflow, drain with wrap-around
        for (int i = 1; i <= 8; i++) begin
            wait_status("s3_ready");
            send_word(W'(i), 10, 10);
        end
        chk("s3_len8", 32'(bus_l.len_out), 32'd8);
        send_bit(1'b1, 10, 10);
        chk("s3_full",   32'(bus_l.full_out), 32'd1);
        chk("s3_status", 32'(bus_l.status_out), 32'd0);
        chk("s3_ovf",    32'(bus_l.overflow_out), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            pop();
            chk("s3_pop", 32'(bus_l.data_out), 32'(i));
        end
        pop();
        chk("s3_pop9",   32'(bus_l.data_out), 32'h08);
        chk("s3_empty",  32'(bus_l.empty_out), 32'd1);

        // Scenario 4: write_in held high for 30 cycles counts as one bit
        wait_status("s4_ready");
        din = 1'b1; win = 1'b1;
        ticks(30);
        win = 1'b0;
        ticks(10);
        chk("s4_status", 32'(bus_l.status_out), 32'd0);
        chk("s4_len",    32'(bus_l.len_out), 32'd0);
        w = 8'hA5;
        for (int k = 1; k < W; k++) send_bit(w[k], 10, 10);
`ifdef DESER_PARITY_EN
        send_bit(^w, 10, 10);
`endif
        chk("s4_len1", 32'(bus_l.len_out), 32'd1);
        pop();
        chk("s4_data", 32'(bus_l.data_out), 32'hA5);

        // Scenario 5: reset after 4 bits, then a clean word
        wait_status("s5_ready");
        for (int k = 0; k < 4; k++) send_bit(1'b1, 10, 10);
        #250 rst_n = 1'b0;
        ticks(2);
        chk("s5_status", 32'(bus_l.status_out), 32'd1);
        chk("s5_len",    32'(bus_l.len_out), 32'd0);
        chk("s5_ovf",    32'(bus_l.overflow_out), 32'd0);
        chk("s5_data",   32'(bus_l.data_out), 32'h0);
        #250 rst_n = 1'b1;
        tick();
        send_word(8'h5A, 10, 10);
        pop();
        chk("s5_word", 32'(bus_l.data_out), 32'h5A);

`ifdef DESER_PARITY_EN
        // Scenario 6: good and bad parity
        wait_status("s6_ready");
        send_word_p(8'h99, 1'b0);
        chk("s6_len1", 32'(bus_l.len_out), 32'd1);
        pop();
        chk("s6_data", 32'(bus_l.data_out), 32'h99);
        p0 = perr_cnt;
        send_word_p(8'h99, 1'b1);
        chk("s6_perr_pulses", 32'(perr_cnt - p0), 32'd1);
        chk("s6_len0", 32'(bus_l.len_out), 32'd0);
`else
        p0 = perr_cnt;
`endif

        // Randomized traffic with background pops and uneven strobes
        rand_pop = 1'b1;
        for (int n = 0; n < 40; n++) begin
            w = W'($urandom);
            if ($urandom_range(0, 1) == 1) wait_status("rnd_ready");
            for (int k = 0; k < W; k++)
                send_bit(w[k], $urandom_range(1, 12), $urandom_range(1, 12));
`ifdef DESER_PARITY_EN
            send_bit((^w) ^ ($urandom_range(0, 3) == 0),
                     $urandom_range(1, 12), $urandom_range(1, 12));
`endif
        end
        rand_pop = 1'b0;
        deq = 1'b0;
        ticks(5);
        repeat (D + 2) pop();
        chk("end_empty", 32'(bus_l.empty_out), 32'd1);
`ifndef DESER_PARITY_EN
        chk("no_perr", 32'(perr_cnt - p0), 32'd0);
`endif
        ticks(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
